// File: rtl/uart_pkg.sv
// UART shared definitions, used by both receiver and transmitter.
//   state_t   : receiver FSM state encoding (PARITY present only when
//               UART_RX_PARITY_EN is defined)
//   START_MID : tick count at the middle of the start bit
//   BIT_TICKS : oversampling ticks per bit
//   DATA_BITS : data bits per frame
//   s_width() : tick-counter width able to hold SB_TICK-1 (at least 4 bits)
package uart_pkg;

    localparam int START_MID = 7;
    localparam int BIT_TICKS = 16;
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } state_t;

    function automatic int s_width(input int sb_tick);
        int w;
        w = $clog2(sb_tick);
        return (w > 4) ? w : 4;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-consumer interface.
// Handshake: rx_valid=1 means dout/frame_err/parity_err hold an unconsumed
// byte; the byte is consumed on any clk where rx_valid=1 and rx_ready=1.
// rxtick pulses once per completed frame whether or not the byte was kept;
// overrun_err is sticky until err_clr. state is the receiver FSM state for
// observation only. parity_err exists only with UART_RX_PARITY_EN.
//   master : receiver side (drives data/status, samples rx_ready/err_clr)
//   slave  : consumer side
interface uart_rx_if;
    import uart_pkg::*;

    logic [7:0] dout;
    logic       rx_valid;
    logic       rxtick;
    logic       frame_err;
    logic       overrun_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif
    logic       rx_ready;
    logic       err_clr;
    state_t     state;

    modport master (
        output dout, rx_valid, rxtick, frame_err, overrun_err, state,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        input  rx_ready, err_clr
    );

    modport slave (
        input  dout, rx_valid, rxtick, frame_err, overrun_err, state,
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        output rx_ready, err_clr
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous rx line. Resets to 1 so the
// idle-high line is not mistaken for a start bit right after reset.
//   clk, rstn : clock, asynchronous active-low reset
//   d         : asynchronous input
//   q         : synchronized output
module uart_sync2 (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampling, 8 data bits, LSB first.
// Optional even-parity bit between data and stop: define UART_RX_PARITY_EN.
//   clk, rstn : clock, asynchronous active-low reset
//   stick     : 16x baud strobe, one clk wide
//   rx        : asynchronous serial line, idle high
//   bus       : consumer interface (dout, rx_valid, rxtick, frame_err,
//               overrun_err, [parity_err], state / rx_ready, err_clr)
// SB_TICK sets the stop-bit length in ticks (16, 24 or 32).
module uart_rx
    import uart_pkg::*;
#(
    parameter int SB_TICK = 16
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     stick,
    input  logic     rx,
    uart_rx_if.master bus
);

    localparam int SW = s_width(SB_TICK);

    logic          rxs;
    state_t        state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [2:0]    n_q, n_d;
    logic [7:0]    b_q, b_d;
    logic          done;

    logic [7:0]    dout_q;
    logic          rx_valid_q, rxtick_q, frame_err_q, overrun_q;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
    logic          parity_err_q;
`endif

    uart_sync2 u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (rx),
        .q    (rxs)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        done    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    s_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                if (stick) begin
                    if (s_q == SW'(START_MID)) begin
                        // Line back high at mid start bit: treat as a glitch.
                        if (!rxs) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (stick) begin
                    if (s_q == SW'(BIT_TICKS - 1)) begin
                        b_d = {rxs, b_q[7:1]};
                        s_d = '0;
                        if (n_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (stick) begin
                    if (s_q == SW'(BIT_TICKS - 1)) begin
                        // Even parity: data ones plus parity bit must be even.
                        par_d   = rxs ^ (^b_q);
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (stick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output holding register. A completed frame is kept if the slot is
    // empty or is being consumed this same clk; otherwise it is dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_q       <= '0;
            rx_valid_q   <= 1'b0;
            rxtick_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            rxtick_q <= done;
            if (done && (!rx_valid_q || bus.rx_ready)) begin
                dout_q       <= b_q;
                frame_err_q  <= ~rxs;
                rx_valid_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= par_q;
`endif
            end else if (rx_valid_q && bus.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            // A new overrun takes priority over a clear in the same clk.
            if (done && rx_valid_q && !bus.rx_ready) begin
                overrun_q <= 1'b1;
            end else if (bus.err_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.dout        = dout_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rxtick      = rxtick_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.overrun_err = overrun_q;
    assign bus.state       = state_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: table of frames plus hand-written sequences for
// glitch rejection, overrun/err_clr and reset in mid-frame.
module tb_uart_rx;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic stick = 1'b0;
    logic rx = 1'b1;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;
    int t0;

    uart_rx_if u_if ();

    uart_rx #(.SB_TICK(16)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .stick (stick),
        .rx    (rx),
        .bus   (u_if.master)
    );

    // clock / pulse monitor
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (u_if.rxtick) tick_cnt++;
    end

    // checker
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // drivers: one stick every 4 clks; rx changes on a negedge
    task automatic do_tick();
        @(negedge clk) stick = 1'b1;
        @(negedge clk) stick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_bit(input logic v, input int n);
        @(negedge clk) rx = v;
        repeat (n) do_tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
        send_bit(par_bit, 16);
`else
        if (par_bit) begin end
`endif
        // A low stop bit is cut short so the line is high again before
        // a stray start could be confirmed.
        if (stop_bit) send_bit(1'b1, 16);
        else          send_bit(1'b0, 12);
        send_bit(1'b1, 20);
    endtask

    task automatic consume();
        @(negedge clk) u_if.rx_ready = 1'b1;
        @(negedge clk) u_if.rx_ready = 1'b0;
        chk("consume_valid", 32'(u_if.rx_valid), 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       par_bit;
        logic [7:0] exp_dout;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

`ifdef UART_RX_PARITY_EN
    localparam int NV = 7;
`else
    localparam int NV = 5;
`endif
    vec_t vecs [NV];

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0};
`ifdef UART_RX_PARITY_EN
        vecs[5] = '{8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1};
        vecs[6] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
`endif
        u_if.rx_ready = 1'b0;
        u_if.err_clr  = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(u_if.state), 32'(IDLE));
        chk("rst_dout", 32'(u_if.dout), 32'h0);
        chk("rst_valid", 32'(u_if.rx_valid), 32'd0);
        chk("rst_rxtick", 32'(u_if.rxtick), 32'd0);
        chk("rst_fe", 32'(u_if.frame_err), 32'd0);
        chk("rst_ovr", 32'(u_if.overrun_err), 32'd0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // table of frames
        for (int i = 0; i < NV; i++) begin
            t0 = tick_cnt;
            send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].par_bit);
            chk($sformatf("vec%0d_dout", i), 32'(u_if.dout), 32'(vecs[i].exp_dout));
            chk($sformatf("vec%0d_valid", i), 32'(u_if.rx_valid), 32'd1);
            chk($sformatf("vec%0d_fe", i), 32'(u_if.frame_err), 32'(vecs[i].exp_fe));
            chk($sformatf("vec%0d_rxtick", i), 32'(tick_cnt - t0), 32'd1);
            chk($sformatf("vec%0d_state", i), 32'(u_if.state), 32'(IDLE));
`ifdef UART_RX_PARITY_EN
            chk($sformatf("vec%0d_pe", i), 32'(u_if.parity_err), 32'(vecs[i].exp_pe));
`endif
            consume();
        end

        // glitch: 4 ticks low, then high
        t0 = tick_cnt;
        send_bit(1'b0, 4);
        send_bit(1'b1, 30);
        chk("glitch_state", 32'(u_if.state), 32'(IDLE));
        chk("glitch_rxtick", 32'(tick_cnt - t0), 32'd0);
        chk("glitch_valid", 32'(u_if.rx_valid), 32'd0);

        // overrun: two frames without consuming
        t0 = tick_cnt;
        send_frame(8'h11, 1'b1, 1'b0);
        chk("ovr_first_flag", 32'(u_if.overrun_err), 32'd0);
        send_frame(8'h22, 1'b1, 1'b1);
        chk("ovr_dout", 32'(u_if.dout), 32'h11);
        chk("ovr_valid", 32'(u_if.rx_valid), 32'd1);
        chk("ovr_flag", 32'(u_if.overrun_err), 32'd1);
        chk("ovr_rxtick", 32'(tick_cnt - t0), 32'd2);
        repeat (5) @(negedge clk);
        chk("ovr_sticky", 32'(u_if.overrun_err), 32'd1);
        @(negedge clk) u_if.err_clr = 1'b1;
        @(negedge clk) u_if.err_clr = 1'b0;
        chk("ovr_clr", 32'(u_if.overrun_err), 32'd0);
        chk("ovr_clr_valid", 32'(u_if.rx_valid), 32'd1);

        // reset during data bit 4 of 0xFF (rx_valid still set from 0x11)
        t0 = tick_cnt;
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 16);
        send_bit(1'b1, 8);
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_state", 32'(u_if.state), 32'(IDLE));
        chk("mid_rst_valid", 32'(u_if.rx_valid), 32'd0);
        chk("mid_rst_dout", 32'(u_if.dout), 32'h0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        send_bit(1'b1, 8 + 16 * 3 + 16 + 20);
        chk("mid_rst_rxtick", 32'(tick_cnt - t0), 32'd0);
        chk("mid_rst_valid2", 32'(u_if.rx_valid), 32'd0);
        t0 = tick_cnt;
        send_frame(8'h81, 1'b1, 1'b0);
        chk("post_rst_dout", 32'(u_if.dout), 32'h81);
        chk("post_rst_valid", 32'(u_if.rx_valid), 32'd1);
        chk("post_rst_fe", 32'(u_if.frame_err), 32'd0);
        chk("post_rst_ovr", 32'(u_if.overrun_err), 32'd0);
        chk("post_rst_rxtick", 32'(tick_cnt - t0), 32'd1);
`ifdef UART_RX_PARITY_EN
        chk("post_rst_pe", 32'(u_if.parity_err), 32'd0);
`endif

        // report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
